// File: rtl/program_loader.sv
// Byte-stream boot loader: parses a count header, assembles little-endian 32-bit
// words into instruction memory, verifies an XOR checksum and holds the core in reset until done.
module program_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        HDR0 = 3'd0,
        HDR1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    state_t            state_r;
    state_t            state_next_s;
    logic [7:0]        count_lo_r;
    logic [ADDR_W:0]   word_cnt_r;
    logic [ADDR_W:0]   word_idx_r;
    logic [1:0]        lane_r;
    logic [23:0]       asm_r;
    logic [7:0]        csum_r;
    logic              accept_s;
    logic              last_word_s;
    logic [16:0]       count_hdr_s;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    assign count_hdr_s = {1'b0, in_data, count_lo_r};
    assign last_word_s = ((word_idx_r + {{ADDR_W{1'b0}}, 1'b1}) == word_cnt_r);

    // Next-state decode; a byte is consumed only in the four loading states.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            HDR0: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = HDR1;
                end else begin
                    state_next_s = HDR0;
                end
            end
            HDR1: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    if (count_hdr_s > MAX_WORDS) begin
                        state_next_s = ERR;
                    end else if (count_hdr_s == 17'd0) begin
                        state_next_s = CSUM;
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = HDR1;
                end
            end
            DATA: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    if ((lane_r == 2'd3) && last_word_s) begin
                        state_next_s = CSUM;
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            CSUM: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = (in_data == csum_r) ? DONE : ERR;
                end else begin
                    state_next_s = CSUM;
                end
            end
            DONE, ERR: begin
                if (start) begin
                    state_next_s = HDR0;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = HDR0;
            end
        endcase
    end

    // State, datapath and registered outputs; status outputs are decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= HDR0;
            count_lo_r <= 8'd0;
            word_cnt_r <= '0;
            word_idx_r <= '0;
            lane_r     <= 2'd0;
            asm_r      <= 24'd0;
            csum_r     <= 8'd0;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            imem_we    <= 1'b0;
            in_ready   <= (state_next_s != DONE) && (state_next_s != ERR);
            core_reset <= (state_next_s != DONE);
            done       <= (state_next_s == DONE);
            error      <= (state_next_s == ERR);
            case (state_r)
                HDR0: begin
                    if (accept_s) begin
                        count_lo_r <= in_data;
                    end
                end
                HDR1: begin
                    if (accept_s) begin
                        word_cnt_r <= count_hdr_s[ADDR_W:0];
                    end
                end
                DATA: begin
                    if (accept_s) begin
                        csum_r <= csum_update(csum_r, in_data);
                        lane_r <= lane_r + 2'd1;
                        if (lane_r == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx_r[ADDR_W-1:0];
                            imem_wdata <= {in_data, asm_r};
                            word_idx_r <= word_idx_r + {{ADDR_W{1'b0}}, 1'b1};
                        end else begin
                            asm_r[{lane_r, 3'b000} +: 8] <= in_data;
                        end
                    end
                end
                DONE, ERR: begin
                    if (start) begin
                        word_idx_r <= '0;
                        lane_r     <= 2'd0;
                        asm_r      <= 24'd0;
                        csum_r     <= 8'd0;
                    end
                end
                default: begin
                    lane_r <= 2'd0;
                end
            endcase
        end
    end

endmodule
